load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, REQ-state cycles without mem_ack before abort; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 core_valid  input  1  core presents access this cycle.
REQ-005 core_ready  output  1  LSU accepts access; high only in IDLE.
REQ-006 core_we  input  1  1 = store, 0 = load.
REQ-007 core_funct3  input  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 core_addr  input  32  byte address.
REQ-009 core_wdata  input  32  store data, low-aligned.
REQ-010 core_done  output  1  one-cycle completion pulse.
REQ-011 core_rdata  output  32  formatted load data, valid with core_done.
REQ-012 core_fault  output  1  access aborted, valid with core_done.
REQ-013 mem_req  output  1  memory request strobe.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  32  word address, bits [1:0] always 00.
REQ-016 mem_be  output  4  byte enables, bit i = byte lane i.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_ack  input  1  memory completion; mem_rdata valid same cycle.
REQ-019 mem_rdata  input  32  memory read word.

Function
REQ-020 FSM states IDLE, REQ, RESP; accept = core_valid & core_ready.
REQ-021 IDLE: on accept, latch we/funct3/addr/wdata; go to REQ, or to RESP with fault if request is illegal (REQ-026) or trapped misaligned (REQ-035).
REQ-022 REQ: mem_req=1 with mem_we/addr/be/wdata from latched request, all stable while in REQ; on mem_ack go to RESP.
REQ-023 REQ timeout: 8-bit counter cleared on REQ entry, increments each REQ cycle without ack; at count == TIMEOUT_CYCLES go to RESP with fault; ack in that same cycle wins (no fault).
REQ-024 RESP: core_done=1 for exactly one cycle, then IDLE; mem_req=0.
REQ-025 Latency: accept at cycle N, ack at N+1 -> core_done at N+2; each extra wait cycle adds one.
REQ-026 Illegal funct3 (011, 110, 111 for loads; anything but 000/001/010 for stores): no mem_req, fault at N+1.
REQ-027 Store enables: sb be = 0001<<addr[1:0], wdata = byte x4; sh be = addr[1] ? 1100 : 0011, wdata = half x2; sw be = 1111.
REQ-028 Loads drive be = 1111; lane select from latched addr; lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through.
REQ-029 core_rdata captured from mem_rdata on ack and held through RESP; zero on fault or store.
REQ-030 mem_ack outside REQ ignored; core_valid outside IDLE ignored (ready=0).
REQ-031 core_fault=0 whenever core_done=0.

Reset
REQ-032 reset high at clock edge: state IDLE, counter 0, latches 0.
REQ-033 Output reset values: core_ready=1 after release, core_done=0, core_fault=0, core_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
REQ-034 Reset mid-operation (REQ or RESP) aborts the access with no core_done; a pending mem_ack is discarded.

Configuration
REQ-035 Macro LSU_MISALIGN_TRAP_EN defined: lh/lhu/sh with addr[0]=1 or lw/sw with addr[1:0]!=00 fault at N+1, no mem_req.
REQ-036 Macro undefined: no misalign fault; halfword ignores addr[0], word ignores addr[1:0] (aligned down).

Verification
REQ-037 sw addr 0x64 data 0x19, ack at N+1 -> mem_addr 0x64, be 1111, wdata 0x00000019, core_done at N+2, fault 0.
REQ-038 lb addr 0x61, mem_rdata 0x1234_80FF -> core_rdata 0xFFFFFF80; lbu same -> 0x00000080.
REQ-039 sh addr 0x62 data 0xABCD -> be 1100, wdata 0xABCDABCD; lhu addr 0x62 rdata 0xBEEF0000 -> 0x0000BEEF.
REQ-040 No ack, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, then core_done=1, fault=1, rdata 0; late ack ignored.
REQ-041 lw addr 0x66: trap build -> fault at N+1, mem_req never high; non-trap build -> mem_addr 0x64, fault 0.
REQ-042 reset asserted during REQ -> next cycle mem_req=0, core_ready=1, no core_done.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose: bridges a single-issue RV32I core to a word-wide memory port.
// One access at a time: the core hands over a load or store, the unit
// issues one word request with byte enables, formats the returned data
// and reports completion with a one-cycle done pulse.
//
// Ports:
//   clk, reset               sole clock; synchronous active-high reset
//   core_valid/core_ready    access handshake (ready only while idle)
//   core_we, core_funct3     store/load select and RV32I width code
//   core_addr, core_wdata    byte address, low-aligned store data
//   core_done                one-cycle completion pulse
//   core_rdata, core_fault   formatted load data / abort flag, valid with done
//   mem_req, mem_we          memory request strobe and write enable
//   mem_addr, mem_be         word address (bits [1:0] = 0), byte-lane enables
//   mem_wdata                lane-replicated store data
//   mem_ack, mem_rdata       memory completion and read word (same cycle)
//
// Parameter: TIMEOUT_CYCLES (1..255) request cycles without mem_ack before
//            the access is aborted with a fault.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned halfword and
//            word accesses instead of silently aligning them down.
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_valid,
    output logic        core_ready,
    input  logic        core_we,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_done,
    output logic [31:0] core_rdata,
    output logic        core_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_cnt;
    logic        r_fault;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_legal;
    logic        w_misalign;
    logic        w_reject;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    // ------------------------------------------------------------------
    // Request classification (evaluated on the incoming core fields)
    // ------------------------------------------------------------------
    assign w_accept = core_valid & (r_state == S_IDLE);

    always_comb begin
        w_legal = 1'b0;
        if (core_we) begin
            w_legal = (core_funct3 == 3'b000) || (core_funct3 == 3'b001) ||
                      (core_funct3 == 3'b010);
        end else begin
            w_legal = (core_funct3 == 3'b000) || (core_funct3 == 3'b001) ||
                      (core_funct3 == 3'b010) || (core_funct3 == 3'b100) ||
                      (core_funct3 == 3'b101);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0] gives the access size for every legal code (01 half, 10 word)
    always_comb begin
        w_misalign = 1'b0;
        case (core_funct3[1:0])
            2'b01:   w_misalign = core_addr[0];
            2'b10:   w_misalign = (core_addr[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end
`else
    // Misaligned halfword/word accesses are aligned down by the lane logic
    assign w_misalign = 1'b0;
`endif

    assign w_reject = ~w_legal | w_misalign;

    // Timeout fires on the cycle that would bring the count to the limit,
    // so the request is held for exactly TIMEOUT_CYCLES cycles. An ack in
    // that same cycle takes priority.
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = ~mem_ack & (w_cnt_inc == TIMEOUT_LIMIT);

    // ------------------------------------------------------------------
    // Store lane steering (from the latched request)
    // ------------------------------------------------------------------
    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
        if (r_we) begin
            case (r_funct3[1:0])
                2'b00: begin
                    w_be        = 4'b0001 << r_addr[1:0];
                    w_wdata_rep = {4{r_wdata[7:0]}};
                end
                2'b01: begin
                    w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata_rep = {2{r_wdata[15:0]}};
                end
                default: begin
                    w_be        = 4'b1111;
                    w_wdata_rep = r_wdata;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load formatting: pick the lane, then sign- or zero-extend
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_lane[r_addr[1:0]];
    assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_load_data = mem_rdata;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_reject ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs (memory side is forced to zero outside REQ)
    always_comb begin
        core_ready = (r_state == S_IDLE);
        core_done  = (r_state == S_RESP);
        core_fault = core_done & r_fault;
        core_rdata = core_done ? r_rdata : 32'd0;
        mem_req    = (r_state == S_REQ);
        mem_we     = mem_req & r_we;
        mem_addr   = mem_req ? {r_addr[31:2], 2'b00} : 32'd0;
        mem_be     = mem_req ? w_be : 4'b0000;
        mem_wdata  = mem_req ? w_wdata_rep : 32'd0;
    end

    // ------------------------------------------------------------------
    // Request latches, timeout counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_cnt    <= 8'd0;
            r_fault  <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we     <= core_we;
                        r_funct3 <= core_funct3;
                        r_addr   <= core_addr;
                        r_wdata  <= core_wdata;
                        r_cnt    <= 8'd0;
                        r_fault  <= w_reject;
                        r_rdata  <= 32'd0;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_fault <= 1'b0;
                        r_rdata <= r_we ? 32'd0 : w_load_data;
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                        r_rdata <= 32'd0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit built with TIMEOUT_CYCLES = 4.
// Expected responses are pushed to a scoreboard queue when an access is
// issued and popped when the unit reports core_done; memory-side outputs
// are captured during the request phase and compared by each test task.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        core_valid;
    logic        core_ready;
    logic        core_we;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_done;
    logic [31:0] core_rdata;
    logic        core_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_valid  (core_valid),
        .core_ready  (core_ready),
        .core_we     (core_we),
        .core_funct3 (core_funct3),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_done   (core_done),
        .core_rdata  (core_rdata),
        .core_fault  (core_fault),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fault;
        logic [31:0] rdata;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // observations of the most recent access
    int          obs_req;
    int          obs_lat;
    logic        obs_done;
    logic        obs_fault;
    logic [31:0] obs_rdata;
    logic        obs_we;
    logic [31:0] obs_maddr;
    logic [3:0]  obs_be;
    logic [31:0] obs_mwdata;
    logic        obs_bad;   // unstable request, ready while busy, or stray fault

    // Issue one access and watch it to completion; ack_wait < 0 never acks.
    task automatic run_access(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_wait, input logic [31:0] rdata);
        int cyc;
        obs_req = 0; obs_lat = 0; obs_done = 1'b0; obs_fault = 1'b0;
        obs_rdata = 32'd0; obs_we = 1'b0; obs_maddr = 32'd0; obs_be = 4'd0;
        obs_mwdata = 32'd0; obs_bad = 1'b0;
        @(negedge clk);
        core_valid = 1'b1; core_we = we; core_funct3 = f3;
        core_addr = addr; core_wdata = wdata;
        @(posedge clk);
        #1;
        core_valid = 1'b0;
        cyc = 0;
        while (!obs_done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            mem_rdata = 32'd0;
            if (core_done) begin
                obs_done = 1'b1; obs_lat = cyc;
                obs_fault = core_fault; obs_rdata = core_rdata;
            end else if (core_ready || core_fault) begin
                obs_bad = 1'b1;
            end
            if (mem_req) begin
                if (obs_req == 0) begin
                    obs_we = mem_we; obs_maddr = mem_addr;
                    obs_be = mem_be; obs_mwdata = mem_wdata;
                end else if (mem_we !== obs_we || mem_addr !== obs_maddr ||
                             mem_be !== obs_be || mem_wdata !== obs_mwdata) begin
                    obs_bad = 1'b1;
                end
                if (obs_req == ack_wait) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
                obs_req++;
            end
        end
        mem_ack = 1'b0;
        $display("txn we=%0d f3=%b addr=%h wdata=%h req_cycles=%0d done=%0d lat=%0d fault=%0d rdata=%h",
                 we, f3, addr, wdata, obs_req, obs_done, obs_lat, obs_fault, obs_rdata);
    endtask

    // Independent reference for load result formatting.
    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] sb_w;
        logic [31:0] sh_w;
        sb_w = w >> (8 * off);
        sh_w = w >> (16 * off[1]);
        case (f3)
            3'b000:  return {{24{sb_w[7]}}, sb_w[7:0]};
            3'b100:  return {24'd0, sb_w[7:0]};
            3'b001:  return {{16{sh_w[15]}}, sh_w[15:0]};
            3'b101:  return {16'd0, sh_w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({core_ready, core_done, core_fault} !== 3'b100) begin
            errors++;
            $display("FAIL reset_core_ctl got ready/done/fault=%b exp 100",
                     {core_ready, core_done, core_fault});
        end
        checks++;
        if (core_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata got %h exp 00000000", core_rdata);
        end
        checks++;
        if ({mem_req, mem_we, mem_be} !== 6'd0) begin
            errors++;
            $display("FAIL reset_mem_ctl got req/we/be=%b exp 000000", {mem_req, mem_we, mem_be});
        end
        checks++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem_bus got addr=%h wdata=%h exp 0/0", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_store_word();
        exp_t e;
        sb.push_back('{fault: 1'b0, rdata: 32'd0, lat: 8'd2});
        run_access(1'b1, 3'b010, 32'h64, 32'h19, 0, 32'd0);
        e = sb.pop_front();
        checks++;
        if (obs_maddr !== 32'h64 || obs_be !== 4'b1111 || obs_mwdata !== 32'h19 ||
            obs_we !== 1'b1 || obs_req != 1 || obs_bad) begin
            errors++;
            $display("FAIL sw_mem got addr=%h be=%b wdata=%h we=%0d req=%0d bad=%0d exp 64/1111/19/1/1/0",
                     obs_maddr, obs_be, obs_mwdata, obs_we, obs_req, obs_bad);
        end
        checks++;
        if (!obs_done || obs_fault !== e.fault || obs_rdata !== e.rdata || obs_lat != 32'(e.lat)) begin
            errors++;
            $display("FAIL sw_resp got done=%0d fault=%0d rdata=%h lat=%0d exp 1/%0d/%h/%0d",
                     obs_done, obs_fault, obs_rdata, obs_lat, e.fault, e.rdata, e.lat);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s   [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
        logic [31:0] addrs [5] = '{32'h61, 32'h61, 32'h62, 32'h60, 32'h64};
        logic [31:0] rds   [5] = '{32'h1234_80FF, 32'h1234_80FF, 32'hBEEF_0000, 32'h0000_8001, 32'hDEAD_BEEF};
        logic [31:0] exps  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF, 32'hFFFF_8001, 32'hDEAD_BEEF};
        int          waits [5] = '{0, 0, 1, 0, 2};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{fault: 1'b0, rdata: exps[i], lat: 8'(2 + waits[i])});
            run_access(1'b0, f3s[i], addrs[i], 32'hFFFF_FFFF, waits[i], rds[i]);
            e = sb.pop_front();
            checks++;
            if (obs_maddr !== {addrs[i][31:2], 2'b00} || obs_be !== 4'b1111 || obs_we !== 1'b0 ||
                obs_req != waits[i] + 1 || obs_bad) begin
                errors++;
                $display("FAIL load%0d_mem got addr=%h be=%b we=%0d req=%0d bad=%0d exp %h/1111/0/%0d/0",
                         i, obs_maddr, obs_be, obs_we, obs_req, obs_bad,
                         {addrs[i][31:2], 2'b00}, waits[i] + 1);
            end
            checks++;
            if (!obs_done || obs_fault !== e.fault || obs_rdata !== e.rdata || obs_lat != 32'(e.lat)) begin
                errors++;
                $display("FAIL load%0d_resp got done=%0d fault=%0d rdata=%h lat=%0d exp 1/%0d/%h/%0d",
                         i, obs_done, obs_fault, obs_rdata, obs_lat, e.fault, e.rdata, e.lat);
            end
        end
    endtask

    task automatic test_store_sub();
        logic [2:0]  f3s   [3] = '{3'b001, 3'b001, 3'b000};
        logic [31:0] addrs [3] = '{32'h62, 32'h60, 32'h63};
        logic [31:0] wds   [3] = '{32'h0000_ABCD, 32'h0000_1357, 32'h0000_005A};
        logic [3:0]  bes   [3] = '{4'b1100, 4'b0011, 4'b1000};
        logic [31:0] mwds  [3] = '{32'hABCD_ABCD, 32'h1357_1357, 32'h5A5A_5A5A};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{fault: 1'b0, rdata: 32'd0, lat: 8'd2});
            run_access(1'b1, f3s[i], addrs[i], wds[i], 0, 32'hFFFF_FFFF);
            e = sb.pop_front();
            checks++;
            if (obs_be !== bes[i] || obs_mwdata !== mwds[i] || obs_we !== 1'b1 || obs_bad) begin
                errors++;
                $display("FAIL store%0d_mem got be=%b wdata=%h we=%0d bad=%0d exp %b/%h/1/0",
                         i, obs_be, obs_mwdata, obs_we, obs_bad, bes[i], mwds[i]);
            end
            checks++;
            if (!obs_done || obs_fault !== e.fault || obs_rdata !== e.rdata || obs_lat != 32'(e.lat)) begin
                errors++;
                $display("FAIL store%0d_resp got done=%0d fault=%0d rdata=%h lat=%0d exp 1/%0d/%h/%0d",
                         i, obs_done, obs_fault, obs_rdata, obs_lat, e.fault, e.rdata, e.lat);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        // no ack at all: 4 request cycles then a faulted completion
        sb.push_back('{fault: 1'b1, rdata: 32'd0, lat: 8'd5});
        run_access(1'b0, 3'b010, 32'h70, 32'd0, -1, 32'd0);
        e = sb.pop_front();
        checks++;
        if (obs_req != 4 || obs_bad) begin
            errors++;
            $display("FAIL timeout_req got req_cycles=%0d bad=%0d exp 4/0", obs_req, obs_bad);
        end
        checks++;
        if (!obs_done || obs_fault !== e.fault || obs_rdata !== e.rdata || obs_lat != 32'(e.lat)) begin
            errors++;
            $display("FAIL timeout_resp got done=%0d fault=%0d rdata=%h lat=%0d exp 1/%0d/%h/%0d",
                     obs_done, obs_fault, obs_rdata, obs_lat, e.fault, e.rdata, e.lat);
        end
        // late ack arriving during the completion cycle must be ignored
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        checks++;
        if (core_done !== 1'b0 || mem_req !== 1'b0 || core_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_ack got done=%0d req=%0d ready=%0d exp 0/0/1", core_done, mem_req, core_ready);
        end
        // ack on the final allowed cycle beats the timeout
        sb.push_back('{fault: 1'b0, rdata: 32'hCAFE_F00D, lat: 8'd5});
        run_access(1'b0, 3'b010, 32'h74, 32'd0, 3, 32'hCAFE_F00D);
        e = sb.pop_front();
        checks++;
        if (!obs_done || obs_req != 4 || obs_fault !== e.fault || obs_rdata !== e.rdata ||
            obs_lat != 32'(e.lat)) begin
            errors++;
            $display("FAIL ack_at_limit got done=%0d req=%0d fault=%0d rdata=%h lat=%0d exp 1/4/%0d/%h/%0d",
                     obs_done, obs_req, obs_fault, obs_rdata, obs_lat, e.fault, e.rdata, e.lat);
        end
    endtask

    task automatic test_misalign();
        exp_t e;
`ifdef LSU_MISALIGN_TRAP_EN
        sb.push_back('{fault: 1'b1, rdata: 32'd0, lat: 8'd1});
`else
        sb.push_back('{fault: 1'b0, rdata: 32'h1122_3344, lat: 8'd2});
`endif
        run_access(1'b0, 3'b010, 32'h66, 32'd0, 0, 32'h1122_3344);
        e = sb.pop_front();
        checks++;
`ifdef LSU_MISALIGN_TRAP_EN
        if (obs_req != 0) begin
            errors++;
            $display("FAIL lw_misalign_req got req_cycles=%0d exp 0", obs_req);
        end
`else
        if (obs_req != 1 || obs_maddr !== 32'h64 || obs_be !== 4'b1111) begin
            errors++;
            $display("FAIL lw_misalign_mem got req=%0d addr=%h be=%b exp 1/00000064/1111",
                     obs_req, obs_maddr, obs_be);
        end
`endif
        checks++;
        if (!obs_done || obs_fault !== e.fault || obs_rdata !== e.rdata || obs_lat != 32'(e.lat)) begin
            errors++;
            $display("FAIL lw_misalign_resp got done=%0d fault=%0d rdata=%h lat=%0d exp 1/%0d/%h/%0d",
                     obs_done, obs_fault, obs_rdata, obs_lat, e.fault, e.rdata, e.lat);
        end
        // sh with addr[0]=1
`ifdef LSU_MISALIGN_TRAP_EN
        sb.push_back('{fault: 1'b1, rdata: 32'd0, lat: 8'd1});
`else
        sb.push_back('{fault: 1'b0, rdata: 32'd0, lat: 8'd2});
`endif
        run_access(1'b1, 3'b001, 32'h63, 32'h0000_1234, 0, 32'd0);
        e = sb.pop_front();
        checks++;
`ifdef LSU_MISALIGN_TRAP_EN
        if (obs_req != 0) begin
            errors++;
            $display("FAIL sh_misalign_req got req_cycles=%0d exp 0", obs_req);
        end
`else
        if (obs_req != 1 || obs_be !== 4'b1100 || obs_mwdata !== 32'h1234_1234) begin
            errors++;
            $display("FAIL sh_misalign_mem got req=%0d be=%b wdata=%h exp 1/1100/12341234",
                     obs_req, obs_be, obs_mwdata);
        end
`endif
        checks++;
        if (!obs_done || obs_fault !== e.fault || obs_rdata !== e.rdata || obs_lat != 32'(e.lat)) begin
            errors++;
            $display("FAIL sh_misalign_resp got done=%0d fault=%0d rdata=%h lat=%0d exp 1/%0d/%h/%0d",
                     obs_done, obs_fault, obs_rdata, obs_lat, e.fault, e.rdata, e.lat);
        end
    endtask

    task automatic test_illegal();
        logic       wes [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0] f3s [5] = '{3'b011, 3'b110, 3'b111, 3'b100, 3'b101};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{fault: 1'b1, rdata: 32'd0, lat: 8'd1});
            run_access(wes[i], f3s[i], 32'h80, 32'h55, 0, 32'h1234_5678);
            e = sb.pop_front();
            checks++;
            if (obs_req != 0 || !obs_done || obs_fault !== e.fault || obs_rdata !== e.rdata ||
                obs_lat != 32'(e.lat)) begin
                errors++;
                $display("FAIL illegal%0d got req=%0d done=%0d fault=%0d rdata=%h lat=%0d exp 0/1/%0d/%h/%0d",
                         i, obs_req, obs_done, obs_fault, obs_rdata, obs_lat, e.fault, e.rdata, e.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] kinds [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010};
        exp_t        e;
        int          k;
        int          w;
        logic        we;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        for (int i = 0; i < 10; i++) begin
            k    = $urandom_range(0, 7);
            w    = $urandom_range(0, 2);
            we   = (k >= 5);
            f3   = kinds[k];
            off  = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) off[0] = 1'b0;
            if (f3[1:0] == 2'b10) off = 2'b00;
            addr = {$urandom_range(0, 32'h00FF_FFFF) & 32'h00FF_FFFC} | {30'd0, off};
            wd   = $urandom;
            rd   = $urandom;
            exp_be = 4'b1111;
            exp_wd = wd;
            if (we && f3 == 3'b000) begin
                exp_be = 4'b0001 << off;
                exp_wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            end else if (we && f3 == 3'b001) begin
                exp_be = off[1] ? 4'b1100 : 4'b0011;
                exp_wd = {wd[15:0], wd[15:0]};
            end
            sb.push_back('{fault: 1'b0, rdata: (we ? 32'd0 : load_model(f3, off, rd)), lat: 8'(2 + w)});
            run_access(we, f3, addr, wd, w, rd);
            e = sb.pop_front();
            checks++;
            if (obs_maddr !== {addr[31:2], 2'b00} || obs_be !== exp_be || obs_we !== we ||
                (we && obs_mwdata !== exp_wd) || obs_bad) begin
                errors++;
                $display("FAIL b2b%0d_mem got addr=%h be=%b we=%0d wdata=%h bad=%0d exp %h/%b/%0d/%h/0",
                         i, obs_maddr, obs_be, obs_we, obs_mwdata, obs_bad,
                         {addr[31:2], 2'b00}, exp_be, we, exp_wd);
            end
            checks++;
            if (!obs_done || obs_fault !== e.fault || obs_rdata !== e.rdata || obs_lat != 32'(e.lat)) begin
                errors++;
                $display("FAIL b2b%0d_resp got done=%0d fault=%0d rdata=%h lat=%0d exp 1/%0d/%h/%0d",
                         i, obs_done, obs_fault, obs_rdata, obs_lat, e.fault, e.rdata, e.lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic stray_done;
        exp_t e;
        @(negedge clk);
        core_valid = 1'b1; core_we = 1'b0; core_funct3 = 3'b010;
        core_addr = 32'h90; core_wdata = 32'd0;
        @(posedge clk);
        #1;
        core_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_req got mem_req=%0d exp 1", mem_req);
        end
        // reset together with a pending ack: the ack must be dropped
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        checks++;
        if (mem_req !== 1'b0 || core_ready !== 1'b1 || core_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after got req=%0d ready=%0d done=%0d exp 0/1/0", mem_req, core_ready, core_done);
        end
        stray_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (core_done !== 1'b0 || mem_req !== 1'b0) stray_done = 1'b1;
        end
        checks++;
        if (stray_done) begin
            errors++;
            $display("FAIL rstmid_quiet got stray done/req=1 exp 0");
        end
        // unit is usable again right away
        sb.push_back('{fault: 1'b0, rdata: 32'h0BAD_CAFE, lat: 8'd2});
        run_access(1'b0, 3'b010, 32'h94, 32'd0, 0, 32'h0BAD_CAFE);
        e = sb.pop_front();
        checks++;
        if (!obs_done || obs_fault !== e.fault || obs_rdata !== e.rdata || obs_lat != 32'(e.lat)) begin
            errors++;
            $display("FAIL rstmid_recover got done=%0d fault=%0d rdata=%h lat=%0d exp 1/%0d/%h/%0d",
                     obs_done, obs_fault, obs_rdata, obs_lat, e.fault, e.rdata, e.lat);
        end
    endtask

    initial begin
        reset = 1'b1;
        core_valid = 1'b0; core_we = 1'b0; core_funct3 = 3'd0;
        core_addr = 32'd0; core_wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_store_word();
        test_loads();
        test_store_sub();
        test_timeout();
        test_misalign();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
